// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the HI/LO multiply/divide unit.
//   - XLEN / ITER / CNT_W : operand width, iteration count and counter width
//   - MDU_* op codes       : operation select encodings
//   - S_* states           : control FSM encodings (plain localparams)
//   - DIV0_LO              : quotient written for a divide by zero
//   - op_is_div / op_is_signed : decode helpers for the op select
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = XLEN;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t S_IDLE = 2'd0;
  localparam mdu_state_t S_PREP = 2'd1;
  localparam mdu_state_t S_CALC = 2'd2;
  localparam mdu_state_t S_FIX  = 2'd3;

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step
// Combinational single-iteration datapath of the multiply/divide unit.
// Operand A is consumed MSB-first, one bit per iteration.
//   acc_i     : 64-bit accumulator (product, or remainder in [31:0])
//   opa_bit_i : current operand-A bit (multiplier / dividend bit)
//   opb_i     : operand B magnitude (multiplicand / divisor)
//   div_i     : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_o     : next accumulator
//   q_bit_o   : quotient bit produced by a divide step (0 for multiply)
module mul_div_step
  import mdu_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              opa_bit_i,
  input  logic [XLEN-1:0]   opb_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   sub;
  logic              ge;

  // Multiply: acc = 2*acc + bit*B, which builds the product MSB-first.
  // Divide: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. The partial remainder is always below
  // the divisor, so the difference fits in XLEN bits and the low bits of the
  // subtraction are exact.
  always_comb begin
    mul_next = {acc_i[2*XLEN-2:0], 1'b0} + (opa_bit_i ? {{XLEN{1'b0}}, opb_i} : '0);
    rem      = {acc_i[XLEN-1:0], opa_bit_i};
    ge       = (rem >= {1'b0, opb_i});
    sub      = rem[XLEN-1:0] - opb_i;
    acc_o    = mul_next;
    q_bit_o  = 1'b0;
    if (div_i) begin
      q_bit_o = ge;
      acc_o   = {{XLEN{1'b0}}, (ge ? sub : rem[XLEN-1:0])};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative HI/LO multiply/divide unit sitting in EX after the forwarding
// muxes. Holds the architectural HI/LO registers and requests a pipeline
// stall while a result is pending and EX needs the unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : EX holds MULT/MULTU/DIV/DIVU (not squashed)
//   op_i         : operation select (MDU_MULT/MULTU/DIV/DIVU)
//   rs_i, rt_i   : forwarded operands
//   mthi_i/mtlo_i: write rs_i to HI / LO
//   hilo_rd_i    : EX holds MFHI/MFLO
//   hi_o, lo_o   : HI/LO registers
//   busy_o       : operation in progress (registered)
//   stall_o      : freeze IF/ID/EX request
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            mthi_i,
  input  logic            mtlo_i,
  input  logic            hilo_rd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            stall_o
);

  mdu_state_t        state;
  logic [1:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   rs_raw;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic [2*XLEN-1:0] acc_next;
  logic              q_bit;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   hi_res;
  logic [XLEN-1:0]   lo_res;
  logic              neg_res;

  mul_div_step u_step (
    .acc_i     (acc),
    .opa_bit_i (opa[XLEN-1]),
    .opb_i     (opb),
    .div_i     (op_is_div(op_q)),
    .acc_o     (acc_next),
    .q_bit_o   (q_bit)
  );

  // Sign correction applied when the magnitudes are done. After CALC, opa
  // holds the quotient (divide) and acc holds the product or, in its low
  // half, the remainder. A zero divisor magnitude means a zero divisor.
  always_comb begin
    neg_res  = sign_a ^ sign_b;
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -opa : opa;
    rem_fix  = sign_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    hi_res   = prod_fix[2*XLEN-1:XLEN];
    lo_res   = prod_fix[XLEN-1:0];
    if (op_is_div(op_q)) begin
      if (opb == '0) begin
        hi_res = rs_raw;
        lo_res = DIV0_LO;
      end else begin
        hi_res = rem_fix;
        lo_res = quot_fix;
      end
    end
  end

  // Control FSM, operand/accumulator registers and HI/LO. Operands are
  // latched on the accept edge because EX moves on once the start is taken.
  // Moves are only honoured in IDLE without a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_o <= 1'b0;
      op_q   <= MDU_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      rs_raw <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state  <= S_PREP;
            busy_o <= 1'b1;
            op_q   <= op_i;
            sign_a <= op_is_signed(op_i) & rs_i[XLEN-1];
            sign_b <= op_is_signed(op_i) & rt_i[XLEN-1];
            rs_raw <= rs_i;
            opa    <= rs_i;
            opb    <= rt_i;
          end else begin
            if (mthi_i) hi_o <= rs_i;
            if (mtlo_i) lo_o <= rs_i;
          end
        end
        S_PREP: begin
          opa   <= sign_a ? -opa : opa;
          opb   <= sign_b ? -opb : opb;
          acc   <= '0;
          cnt   <= '0;
          state <= S_CALC;
        end
        S_CALC: begin
          acc <= acc_next;
          opa <= {opa[XLEN-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          hi_o   <= hi_res;
          lo_o   <= lo_res;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = busy_o & (start_i | mthi_i | mtlo_i | hilo_rd_i);

endmodule
